hood_mode_scheduler: RTL

Fan-mode sequencer for the range hood. It converts menu and mode-button pulses into the smoke-level state and enforces the timed modes: a one-shot hurricane (level 3) window, a delayed return from hurricane to standby, and the self-clean cycle. It sits between the input conditioning block and the work-time block. It drives `state_smoke_lvl`, `countsecond`, the `state` work flag consumed by the time-keeping logic, and a pulse that clears accumulated work time after cleaning.

---
 rtl/hood_mode_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hood_mode_scheduler.sv
// rtl/hood_mode_scheduler.sv - range hood fan-mode sequencer with timed hurricane, return and self-clean modes
module hood_mode_scheduler #(
    parameter int HURRICANE_SEC = 60,
    parameter int RETURN_SEC    = 60,
    parameter int CLEAN_SEC     = 180,
    parameter int CW            = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_1hz,
    input  logic          power_on,
    input  logic          menu,
    input  logic [3:0]    btn_mode_smoke,
    output logic [3:0]    state_smoke_lvl,
    output logic [CW-1:0] countsecond,
    output logic          state,
    output logic          hurricane_used,
    output logic          clean_done
);

    typedef enum logic [2:0] {
        S_OFF, S_STANDBY, S_MENU, S_LVL1, S_LVL2, S_LVL3, S_L3_RET, S_CLEAN
    } st_t;

    localparam logic [CW-1:0] HUR_LOAD = CW'(HURRICANE_SEC);
    localparam logic [CW-1:0] RET_LOAD = CW'(RETURN_SEC);
    localparam logic [CW-1:0] CLN_LOAD = CW'(CLEAN_SEC);
    localparam logic [CW-1:0] ONE      = CW'(1);

    st_t           st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          used_n, done_n;
    logic          tick_live;

    // A tick only counts when the counter is running; expiry is the tick that takes it from 1 to 0.
    assign tick_live = tick_1hz && (cnt != '0);

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        used_n = hurricane_used;
        done_n = 1'b0;
        if (!power_on) begin
            st_n   = S_OFF;
            cnt_n  = '0;
            used_n = 1'b0;
        end else begin
            case (st)
                S_OFF:     st_n = S_STANDBY;
                S_STANDBY: if (menu) st_n = S_MENU;
                S_MENU: begin
                    if (menu) begin
                        st_n = S_STANDBY;
                    end else begin
                        case (btn_mode_smoke)
                            4'b0001: st_n = S_LVL1;
                            4'b0010: st_n = S_LVL2;
                            4'b0100: begin
                                if (!hurricane_used) begin
                                    st_n   = S_LVL3;
                                    cnt_n  = HUR_LOAD;
                                    used_n = 1'b1;
                                end
                            end
                            4'b1000: begin
                                st_n  = S_CLEAN;
                                cnt_n = CLN_LOAD;
                            end
                            default: st_n = S_MENU;
                        endcase
                    end
                end
                S_LVL1, S_LVL2: begin
                    if (menu)                          st_n = S_STANDBY;
                    else if (btn_mode_smoke == 4'b0001) st_n = S_LVL1;
                    else if (btn_mode_smoke == 4'b0010) st_n = S_LVL2;
                end
                S_LVL3: begin
                    if (menu) begin
                        st_n  = S_L3_RET;
                        cnt_n = RET_LOAD;
                    end else if (tick_live) begin
                        cnt_n = cnt - ONE;
                        if (cnt == ONE) st_n = S_LVL2;
                    end
                end
                S_L3_RET: begin
                    if (tick_live) begin
                        cnt_n = cnt - ONE;
                        if (cnt == ONE) st_n = S_STANDBY;
                    end
                end
                S_CLEAN: begin
                    if (tick_live) begin
                        cnt_n = cnt - ONE;
                        if (cnt == ONE) begin
                            st_n   = S_STANDBY;
                            done_n = 1'b1;
                        end
                    end
                end
                default: st_n = S_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they land on the same edge as the transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st              <= S_OFF;
            cnt             <= '0;
            hurricane_used  <= 1'b0;
            clean_done      <= 1'b0;
            state_smoke_lvl <= 4'b0000;
            state           <= 1'b0;
            countsecond     <= '0;
        end else begin
            st             <= st_n;
            cnt            <= cnt_n;
            hurricane_used <= used_n;
            clean_done     <= done_n;
            case (st_n)
                S_LVL1:           state_smoke_lvl <= 4'b0001;
                S_LVL2:           state_smoke_lvl <= 4'b0010;
                S_LVL3, S_L3_RET: state_smoke_lvl <= 4'b0100;
                S_CLEAN:          state_smoke_lvl <= 4'b1000;
                default:          state_smoke_lvl <= 4'b0000;
            endcase
            state       <= (st_n == S_LVL1) || (st_n == S_LVL2) ||
                           (st_n == S_LVL3) || (st_n == S_L3_RET);
            countsecond <= ((st_n == S_LVL3) || (st_n == S_L3_RET) || (st_n == S_CLEAN))
                           ? cnt_n : '0;
        end
    end

endmodule
